// File: rtl/buffer_arb.sv
// Shared simple-dual-port feature buffer with NUM_WR writers and NUM_RD readers.
// Each side has a valid/ready handshake arbiter, and the read side is a tag-routed pipeline.

module buffer_arb_arb #(
    parameter int    N    = 2,
    parameter string MODE = "fixed"
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = PW + 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic [SW-1:0] sum;

    // Search runs from the farthest candidate back to the nearest, so the last hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        sum     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = (MODE == "rr") ? ({1'b0, ptr} + SW'(i)) : SW'(i);
            if (sum >= SW'(N)) sum = sum - SW'(N);
            if (req[sum[PW-1:0]] && rst_n) begin
                gnt                = '0;
                gnt[sum[PW-1:0]]   = 1'b1;
                gnt_idx            = sum[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (MODE == "rr" && |gnt)
            ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
endmodule

module buffer_arb_lane #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tag,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= tag;
            data  <= tag ? din : '0;
        end
    end
endmodule

module buffer_arb #(
    parameter int    ADDR_WIDTH         = 11,
    parameter int    DATA_WIDTH         = 512,
    parameter int    NUM_WR             = 2,
    parameter int    NUM_RD             = 2,
    parameter int    RAM_LATENCY        = 2,
    parameter string ARB_MODE           = "fixed",
    parameter string MEM_POOL_PRIMITIVE = "auto"
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_WR-1:0]            wr_valid,
    output logic [NUM_WR-1:0]            wr_ready,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_RD-1:0]            rd_ready,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_data_valid,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (NUM_WR < 1 || NUM_WR > 8 || NUM_RD < 1 || NUM_RD > 8 ||
        RAM_LATENCY < 1 || RAM_LATENCY > 4 ||
        !(ARB_MODE == "fixed" || ARB_MODE == "rr") ||
        !(MEM_POOL_PRIMITIVE == "ultra" || MEM_POOL_PRIMITIVE == "block" ||
          MEM_POOL_PRIMITIVE == "distributed" || MEM_POOL_PRIMITIVE == "auto")) begin : g_bad_cfg
        $error("buffer_arb: unsupported parameter combination");
    end

    logic [NUM_WR-1:0] wr_gnt;
    logic [NUM_RD-1:0] rd_gnt;

    buffer_arb_arb #(.N(NUM_WR), .MODE(ARB_MODE)) u_wr_arb (
        .clk(clk), .rst_n(rst_n), .req(wr_valid), .gnt(wr_gnt));
    buffer_arb_arb #(.N(NUM_RD), .MODE(ARB_MODE)) u_rd_arb (
        .clk(clk), .rst_n(rst_n), .req(rd_valid), .gnt(rd_gnt));

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;

    // Grant-selected request fields; all-zero on idle cycles.
    logic [ADDR_WIDTH-1:0] wr_addr_sel;
    logic [DATA_WIDTH-1:0] wr_data_sel;
    logic [ADDR_WIDTH-1:0] rd_addr_sel;

    always_comb begin
        wr_addr_sel = '0;
        wr_data_sel = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_gnt[i]) begin
                wr_addr_sel = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_sel = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rd_addr_sel = '0;
        for (int i = 0; i < NUM_RD; i++)
            if (rd_gnt[i]) rd_addr_sel = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  re_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    // Stage 0 sits beside raddr_q; stage k sits beside dout_pipe[k-1].
    logic [RAM_LATENCY:0][NUM_RD-1:0] tag_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            re_q     <= 1'b0;
            raddr_q  <= '0;
            tag_pipe <= '0;
        end else begin
            we_q     <= |wr_gnt;
            waddr_q  <= wr_addr_sel;
            wdata_q  <= wr_data_sel;
            re_q     <= |rd_gnt;
            raddr_q  <= rd_addr_sel;
            tag_pipe <= {tag_pipe[RAM_LATENCY-1:0], rd_gnt};
        end
    end

    (* ram_style = MEM_POOL_PRIMITIVE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [RAM_LATENCY-1:0][DATA_WIDTH-1:0] dout_pipe;

    always_ff @(posedge clk) begin
        if (we_q) mem[waddr_q] <= wdata_q;
    end

    // Read samples mem on the same edge the write commits, which gives read-first collisions.
    always_ff @(posedge clk) begin
        if (re_q) dout_pipe[0] <= mem[raddr_q];
        for (int k = 1; k < RAM_LATENCY; k++)
            dout_pipe[k] <= dout_pipe[k-1];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_lane
        buffer_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .tag   (tag_pipe[RAM_LATENCY][i]),
            .din   (dout_pipe[RAM_LATENCY-1]),
            .valid (rd_data_valid[i]),
            .data  (rd_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: doc/buffer_arb.md
# buffer_arb

Parametrised on-chip feature buffer: one simple-dual-port RAM shared by NUM_WR write requesters and NUM_RD read requesters, with per-port valid/ready handshakes. Arbitration is fixed-priority or round-robin, and RAM read latency is configurable. It sits between the load/save DMA engines and the MM/aggregation compute units. It supersedes the two-writer/two-reader buffers, which had no back-pressure and silently dropped losing requests.

## Interface
- ADDR_WIDTH, 11, word address width; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 512, word width in bits
- NUM_WR, 2, number of write ports (1..8)
- NUM_RD, 2, number of read ports (1..8)
- RAM_LATENCY, 2, RAM read latency in cycles (1..4)
- ARB_MODE, "fixed", "fixed" (lowest index wins) or "rr" (round-robin)
- MEM_POOL_PRIMITIVE, "auto", RAM primitive: "ultra", "block", "distributed" or "auto"
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  NUM_WR  write request per port
- wr_ready  out  NUM_WR  write grant per port (combinational)
- wr_addr  in  NUM_WR*ADDR_WIDTH  packed; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wr_data  in  NUM_WR*DATA_WIDTH  packed likewise
- rd_valid  in  NUM_RD  read request per port
- rd_ready  out  NUM_RD  read grant per port (combinational)
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed
- rd_data_valid  out  NUM_RD  one-cycle pulse per returned word
- rd_data  out  NUM_RD*DATA_WIDTH  packed; zero when that port's valid is low

## Operation
- Write and read arbiters are independent. At most one write and one read are granted per cycle.
- A request is accepted when valid && ready in the same cycle.
- Requesters hold valid, addr and data stable until accepted. valid must not depend on ready.
- ready is one-hot or zero, and asserts only on a port whose valid is high.
- Fixed mode: the lowest-index valid port is granted.
- Round-robin mode: one pointer per arbiter, reset to 0. The search starts at the pointer. After a grant to port k, the pointer becomes (k+1) mod N. The pointer is unchanged on idle cycles.
- Write path: the accepted {addr, data} is registered with we=1, and the RAM writes it on the next edge. Idle cycles register we=0 with addr and data zeroed.
- Read path: the accepted address is registered with en=1, along with a one-hot destination tag of NUM_RD bits. The tag follows a RAM_LATENCY-stage shift register. An output stage then routes the RAM data to the tagged port, sets its rd_data_valid, and zeroes every other port.
- Collision semantics are read-first. A read accepted in the same cycle as a write to the same address returns the old word. A read accepted one or more cycles after the write returns the new word.
- Reads of never-written addresses return 0, because the RAM is zero-initialised.
- No request is ever dropped. Losing ports see ready=0 and retry.

## Timing
- Reset (asynchronous, active-low): every output register and pipeline stage clears immediately.
  - rd_data_valid=0, rd_data=0, tag pipe=0, we=0, en=0, RR pointers=0.
  - wr_ready/rd_ready are 0 while rst_n=0.
- Reset mid-operation: in-flight reads are discarded, and no rd_data_valid is produced for them after release. A write registered but not yet committed is lost.
- Read latency: acceptance in cycle T gives rd_data_valid high in cycle T+RAM_LATENCY+2. Sequence: input register, RAM_LATENCY stages, output register.
- Throughput: one read and one write per cycle sustained. Back-to-back reads return in order on consecutive cycles.
- Write visibility: a read accepted at T+1 or later sees a write accepted at T.
- wr_ready/rd_ready are combinational from wr_valid/rd_valid and the pointer. There is no path from any input to a registered output within the same cycle.

## Test plan
- Reset, then write port 1 addr 0x005 data 0xA5…A5; at T+1 read port 0 addr 0x005 -> rd_data_valid[0]=1 at T+1+RAM_LATENCY+2, data 0xA5…A5; rd_data[1] stays 0.
- Fixed mode, NUM_WR=2: both wr_valid high for 3 cycles, port 0 held -> wr_ready=01 for all 3 cycles. Drop port 0 -> wr_ready=10 next cycle.
- RR mode, NUM_RD=3: all rd_valid held high for 6 cycles -> rd_ready grant order 0,1,2,0,1,2. Returned data appears on ports in the same order, 1 per cycle.
- Same-cycle collision: addr 0x010 holds 0x11…; write 0x22… and read 0x010 accepted in the same cycle -> returns 0x11…. Re-read one cycle later -> returns 0x22….
- Sweep RAM_LATENCY 1..4: a burst of 16 reads to addrs 0..15 -> 16 consecutive valid pulses with matching data, first at acceptance+RAM_LATENCY+2.
- Assert rst_n=0 with 3 reads in flight -> all outputs 0 at once. After release, no rd_data_valid pulses for 8 cycles, and RR pointers restart at port 0.
